multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 99 +++++++++
 tb/tb_multiport_regfile.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// Two-read / two-write register file (port B wins on a shared write address) with a sweep-clear FSM
// that restores init values one register per cycle. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module multiport_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                ZERO_REG = 1,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h3ffffffc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int                NREG        = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SWEEP_START = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NREG - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_idx;
  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok_a;
  logic              wr_ok_b;

  function automatic logic [DATA_W-1:0] init_val(input int idx);
    return (idx == SP_IDX) ? SP_INIT : '0;
  endfunction

  // A write is live only in IDLE, outside reset, and not aimed at a hardwired zero register.
  assign wr_ok_a = wr_en_a && !reset && (state == IDLE) && !((ZERO_REG != 0) && (wr_addr_a == '0));
  assign wr_ok_b = wr_en_b && !reset && (state == IDLE) && !((ZERO_REG != 0) && (wr_addr_b == '0));

  assign busy     = (state == CLEAR);
  assign clr_done = (state == CLEAR) && (sweep_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sweep_idx <= SWEEP_START;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= init_val(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (wr_ok_a) regs[wr_addr_a] <= wr_data_a;
          if (wr_ok_b) regs[wr_addr_b] <= wr_data_b;
          if (clr_req) begin
            state     <= CLEAR;
            sweep_idx <= SWEEP_START;
          end
        end
        CLEAR: begin
          regs[sweep_idx] <= init_val(int'(sweep_idx));
          if (sweep_idx == LAST_IDX) begin
            state     <= IDLE;
            sweep_idx <= SWEEP_START;
          end else begin
            sweep_idx <= sweep_idx + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data1 = regs[rd_addr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_b && (wr_addr_b == rd_addr1))      rd_data1 = wr_data_b;
    else if (wr_ok_a && (wr_addr_a == rd_addr1)) rd_data1 = wr_data_a;
`endif
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_b && (wr_addr_b == rd_addr2))      rd_data2 = wr_data_b;
    else if (wr_ok_a && (wr_addr_a == rd_addr2)) rd_data2 = wr_data_a;
`endif
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) rd_data2 = '0;
  end

endmodule

// File: tb/tb_multiport_regfile.sv
// Randomised and directed bench for multiport_regfile against a behavioural array model.
module tb_multiport_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr_a, wr_addr_b;
  logic [31:0] rd_data1, rd_data2, wr_data_a, wr_data_b;
  logic        wr_en_a, wr_en_b, clr_req, busy, clr_done;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus the sweep position (0 = no sweep running).
  logic [31:0] mem [32];
  int          sweep_next;

  multiport_regfile dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_of(input int i);
    return (i == 29) ? 32'h3ffffffc : 32'h0;
  endfunction

  function automatic bit m_busy();
    return sweep_next != 0;
  endfunction

  function automatic bit m_done();
    return sweep_next == 31;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = init_of(i);
    sweep_next = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && !m_busy()) begin
      if (wr_en_b && wr_addr_b == a) return wr_data_b;
      if (wr_en_a && wr_addr_a == a) return wr_data_a;
    end
`endif
    return mem[a];
  endfunction

  task automatic model_edge();
    if (m_busy()) begin
      mem[sweep_next] = init_of(sweep_next);
      sweep_next = (sweep_next == 31) ? 0 : sweep_next + 1;
    end else begin
      if (wr_en_a && wr_addr_a != 5'd0) mem[wr_addr_a] = wr_data_a;
      if (wr_en_b && wr_addr_b != 5'd0) mem[wr_addr_b] = wr_data_b;
      if (clr_req) sweep_next = 1;
    end
  endtask

  // Advance one clock; returns 1ns after the falling edge, ready for new inputs.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    wr_en_a = 1'b0; wr_en_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'hffff_ffff; clr_req = 1'b1;
    rd_addr1 = 5'd29; rd_addr2 = 5'd7;
    tick(); tick();
    checks++; if (rd_data1 !== 32'h3ffffffc) begin errors++; $display("FAIL reset_sp: got %h want %h", rd_data1, 32'h3ffffffc); end
    checks++; if (rd_data2 !== 32'h0) begin errors++; $display("FAIL reset_r7: got %h want 0", rd_data2); end
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_fsm: busy %b done %b want 0 0", busy, clr_done); end
    quiet();
    reset = 1'b0;
    #1;
    checks++; if (rd_data1 !== 32'h3ffffffc) begin errors++; $display("FAIL release_sp: got %h want %h", rd_data1, 32'h3ffffffc); end
    checks++; if (rd_data2 !== 32'h0) begin errors++; $display("FAIL release_r7: got %h want 0", rd_data2); end
    tick();
  endtask

  task automatic test_dual_write();
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'h11;
    wr_en_b = 1'b1; wr_addr_b = 5'd5; wr_data_b = 32'h22;
    tick();
    wr_addr_a = 5'd8; wr_data_a = 32'haa; wr_addr_b = 5'd9; wr_data_b = 32'hbb;
    rd_addr1 = 5'd5;
    tick();
    quiet();
    #1;
    checks++; if (rd_data1 !== 32'h22) begin errors++; $display("FAIL same_addr_b_wins: got %h want 22", rd_data1); end
    rd_addr1 = 5'd8; rd_addr2 = 5'd9;
    #1;
    checks++; if (rd_data1 !== 32'haa || rd_data2 !== 32'hbb) begin errors++; $display("FAIL diff_addr: got %h %h want aa bb", rd_data1, rd_data2); end
    tick();
  endtask

  task automatic test_zero_reg();
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hdead;
    rd_addr1 = 5'd0;
    #1;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL zero_same_cycle: got %h want 0", rd_data1); end
    tick();
    quiet();
    #1;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL zero_next_cycle: got %h want 0", rd_data1); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'hab;
    rd_addr1 = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hab;
`else
    want = 32'h0;
`endif
    checks++; if (rd_data1 !== want) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", rd_data1, want); end
    tick();
    quiet();
    #1;
    checks++; if (rd_data1 !== 32'hab) begin errors++; $display("FAIL bypass_next_cycle: got %h want ab", rd_data1); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en_a = 1'($urandom_range(0, 1)); wr_addr_a = 5'($urandom_range(0, 31)); wr_data_a = $urandom;
      wr_en_b = 1'($urandom_range(0, 1)); wr_data_b = $urandom;
      wr_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr_a : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr_a : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr_b : 5'($urandom_range(0, 31));
      #1;
      checks++; if (rd_data1 !== exp_rd(rd_addr1)) begin errors++; $display("FAIL rand_rd1 a=%0d: got %h want %h", rd_addr1, rd_data1, exp_rd(rd_addr1)); end
      checks++; if (rd_data2 !== exp_rd(rd_addr2)) begin errors++; $display("FAIL rand_rd2 a=%0d: got %h want %h", rd_addr2, rd_data2, exp_rd(rd_addr2)); end
      tick();
    end
    quiet();
  endtask

  task automatic read_all_init(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i + 16);
      #1;
      checks++; if (rd_data1 !== init_of(i)) begin errors++; $display("FAIL %s r%0d: got %h want %h", tag, i, rd_data1, init_of(i)); end
      checks++; if (rd_data2 !== init_of(i + 16)) begin errors++; $display("FAIL %s r%0d: got %h want %h", tag, i + 16, rd_data2, init_of(i + 16)); end
      tick();
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    for (int i = 1; i < 32; i += 2) begin
      wr_en_a = 1'b1; wr_addr_a = 5'(i);     wr_data_a = 32'h55;
      wr_en_b = 1'b1; wr_addr_b = 5'(i + 1); wr_data_b = 32'h55;
      tick();
    end
    quiet();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      wr_en_a = (c == 5); wr_addr_a = 5'd4; wr_data_a = 32'h77;
      rd_addr1 = 5'd4; rd_addr2 = 5'(c);
      #1;
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL clr_busy c=%0d: got %b want %b", c, busy, m_busy()); end
      checks++; if (clr_done !== m_done()) begin errors++; $display("FAIL clr_done c=%0d: got %b want %b", c, clr_done, m_done()); end
      checks++; if (rd_data1 !== exp_rd(rd_addr1)) begin errors++; $display("FAIL clr_rd4 c=%0d: got %h want %h", c, rd_data1, exp_rd(rd_addr1)); end
      checks++; if (rd_data2 !== exp_rd(rd_addr2)) begin errors++; $display("FAIL clr_rd2 c=%0d: got %h want %h", c, rd_data2, exp_rd(rd_addr2)); end
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_cyc = c; end
      tick();
    end
    quiet();
    checks++; if (busy_cnt != 31) begin errors++; $display("FAIL clr_busy_len: got %0d want 31", busy_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 31) begin errors++; $display("FAIL clr_done_pos: got %0d pulses at %0d want 1 at 31", done_cnt, done_cyc); end
    read_all_init("clr_final");
  endtask

  task automatic test_reset_mid_sweep();
    int done_cnt = 0;
    wr_en_a = 1'b1; wr_addr_a = 5'd20; wr_data_a = 32'h1234;
    wr_en_b = 1'b1; wr_addr_b = 5'd29; wr_data_b = 32'h5678;
    tick();
    quiet();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL mid_reset_fsm: busy %b done %b want 0 0", busy, clr_done); end
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'hcafe; clr_req = 1'b1;
    read_all_init("mid_reset");
    quiet();
    reset = 1'b0;
    for (int c = 0; c < 35; c++) begin
      if (clr_done === 1'b1) done_cnt++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy c=%0d: got %b want 0", c, busy); end
      tick();
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    clr_req = 1'b1;
    for (int c = 0; c < 70; c++) begin
      rd_addr1 = 5'($urandom_range(0, 31));
      #1;
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, m_busy()); end
      checks++; if (clr_done !== m_done()) begin errors++; $display("FAIL b2b_done c=%0d: got %b want %b", c, clr_done, m_done()); end
      checks++; if (rd_data1 !== exp_rd(rd_addr1)) begin errors++; $display("FAIL b2b_rd c=%0d: got %h want %h", c, rd_data1, exp_rd(rd_addr1)); end
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    clr_req = 1'b0;
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    wr_addr_a = '0; wr_addr_b = '0; wr_data_a = '0; wr_data_b = '0;
    rd_addr1 = '0; rd_addr2 = '0;
    model_reset();
    @(negedge clk);
    #1;
    test_reset();
    test_dual_write();
    test_zero_reg();
    test_bypass();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
